// File: rtl/fme_pkg.sv
// Shared definitions for the FME quarter-pel scheduler.
// Holds the sample width and the scheduler FSM state encoding.
package fme_pkg;

  localparam int PIX_W = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } fme_state_t;

endpackage

// File: rtl/fme_avg2.sv
// One lane of the quarter-pel averager.
// Registered 2-input rounding average with a pass-through selection and a
// clock enable. When the enable is low the output holds, which is how a
// downstream stall freezes this stage.
module fme_avg2
  import fme_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             bypass,
  input  logic [PIX_W-1:0] x,
  input  logic [PIX_W-1:0] y,
  input  logic [PIX_W-1:0] sel,
  output logic [PIX_W-1:0] q
);

  logic [PIX_W-1:0] q_reg;
  logic [PIX_W-1:0] avg;

  // One extra bit of headroom so 0xFF + 0xFF + 1 cannot wrap before the shift.
  assign avg = PIX_W'(({1'b0, x} + {1'b0, y} + 9'd1) >> 1);

  // Output register: captures either the average or the selected sample.
  always_ff @(posedge clk) begin
    if (rst) begin
      q_reg <= '0;
    end else if (en) begin
      q_reg <= bypass ? sel : avg;
    end
  end

  assign q = q_reg;

endmodule

// File: rtl/fme_qpel_sched.sv
// Quarter-pel rounding-average scheduler for one FME prediction block.
// Walks the block in row-major lane-group order, reads the integer-pel (A)
// and half-pel (B) buffers, and streams LANES averaged samples per beat.
// Pipeline: rd_en -> buffer data (+1) -> averager register (+2) -> out_valid.
// A downstream stall (out_valid & !out_ready) freezes every stage.
// Optional build macro FME_PERF_CNT_EN adds busy/stall cycle counters.
module fme_qpel_sched
  import fme_pkg::*;
#(
  parameter int BLK_W = 8,
  parameter int BLK_H = 8,
  parameter int LANES = 4,
  localparam int GRPS  = BLK_W / LANES,
  localparam int ROW_W = (BLK_H > 1) ? $clog2(BLK_H) : 1,
  localparam int GRP_W = (GRPS > 1) ? $clog2(GRPS) : 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [1:0]             frac_x,
  input  logic [1:0]             frac_y,
  output logic                   busy,
  output logic                   done,
  output logic                   rd_en,
  output logic [ROW_W-1:0]       rd_row,
  output logic [GRP_W-1:0]       rd_grp,
  input  logic [LANES*PIX_W-1:0] a_data,
  input  logic [LANES*PIX_W-1:0] b_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [LANES*PIX_W-1:0] out_data,
`ifdef FME_PERF_CNT_EN
  output logic [15:0]            perf_busy_cyc,
  output logic [15:0]            perf_stall_cyc,
`endif
  output logic                   out_last
);

  localparam int BEATS  = BLK_H * GRPS;
  localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

  fme_state_t       state_reg, state_next;
  logic [ROW_W-1:0] row_reg;
  logic [GRP_W-1:0] grp_reg;
  logic [BEAT_W-1:0] beat_reg;
  logic [1:0]       frac_x_reg, frac_y_reg;
  logic             busy_reg, done_reg;
  logic             s1_valid_reg, out_valid_reg;

  logic stall, advance, accept, rd_fire, last_rd, beat_ok, last_beat, avg_en;
  logic bypass, sel_a;

  // A beat presented but not taken holds the whole pipe in place.
  assign stall     = out_valid_reg & ~out_ready;
  assign advance   = ~stall;
  // The cycle done pulses the FSM is already IDLE; a start there is dropped.
  assign accept    = (state_reg == IDLE) & start & ~done_reg;
  assign rd_fire   = (state_reg == RUN) & advance;
  assign last_rd   = (row_reg == ROW_W'(BLK_H - 1)) & (grp_reg == GRP_W'(GRPS - 1));
  assign beat_ok   = out_valid_reg & out_ready;
  assign last_beat = out_valid_reg & (beat_reg == BEAT_W'(BEATS - 1));
  assign avg_en    = advance & s1_valid_reg;

  // Averaging whenever either fraction is odd; otherwise pick A at (0,0), else B.
  assign bypass = ~(frac_x_reg[0] | frac_y_reg[0]);
  assign sel_a  = (frac_x_reg == 2'd0) && (frac_y_reg == 2'd0);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic: RUN until the final read issues, DRAIN until it leaves.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (accept) state_next = RUN;
      RUN:     if (rd_fire && last_rd) state_next = DRAIN;
      DRAIN:   if (beat_ok && last_beat) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Read address walk: lane group fastest, then row; both wrap to zero at the end.
  always_ff @(posedge clk) begin
    if (rst) begin
      row_reg <= '0;
      grp_reg <= '0;
    end else if (accept) begin
      row_reg <= '0;
      grp_reg <= '0;
    end else if (rd_fire) begin
      if (grp_reg == GRP_W'(GRPS - 1)) begin
        grp_reg <= '0;
        row_reg <= (row_reg == ROW_W'(BLK_H - 1)) ? '0 : row_reg + 1'b1;
      end else begin
        grp_reg <= grp_reg + 1'b1;
      end
    end
  end

  // Output beat counter, used to flag the final beat of the block.
  always_ff @(posedge clk) begin
    if (rst) begin
      beat_reg <= '0;
    end else if (accept) begin
      beat_reg <= '0;
    end else if (beat_ok) begin
      beat_reg <= last_beat ? '0 : beat_reg + 1'b1;
    end
  end

  // Block control: latch the mode, raise busy on accept, pulse done after the last beat.
  always_ff @(posedge clk) begin
    if (rst) begin
      frac_x_reg <= 2'd0;
      frac_y_reg <= 2'd0;
      busy_reg   <= 1'b0;
      done_reg   <= 1'b0;
    end else begin
      done_reg <= beat_ok & last_beat;
      if (accept) begin
        frac_x_reg <= frac_x;
        frac_y_reg <= frac_y;
        busy_reg   <= 1'b1;
      end else if (beat_ok && last_beat) begin
        busy_reg <= 1'b0;
      end
    end
  end

  // Valid flags for the buffer-data stage and the averager stage; frozen on stall.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_reg  <= 1'b0;
      out_valid_reg <= 1'b0;
    end else if (advance) begin
      s1_valid_reg  <= rd_fire;
      out_valid_reg <= s1_valid_reg;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < LANES; gi++) begin : g_lane
      logic [PIX_W-1:0] a_pix, b_pix;
      assign a_pix = a_data[gi*PIX_W +: PIX_W];
      assign b_pix = b_data[gi*PIX_W +: PIX_W];
      fme_avg2 u_avg (
        .clk    (clk),
        .rst    (rst),
        .en     (avg_en),
        .bypass (bypass),
        .x      (a_pix),
        .y      (b_pix),
        .sel    (sel_a ? a_pix : b_pix),
        .q      (out_data[gi*PIX_W +: PIX_W])
      );
    end
  endgenerate

`ifdef FME_PERF_CNT_EN
  logic [15:0] perf_busy_reg, perf_stall_reg;

  // Saturating cycle counters, cleared by an accepted start and held after done.
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_busy_reg  <= '0;
      perf_stall_reg <= '0;
    end else if (accept) begin
      perf_busy_reg  <= '0;
      perf_stall_reg <= '0;
    end else begin
      if (busy_reg && perf_busy_reg != 16'hFFFF) begin
        perf_busy_reg <= perf_busy_reg + 16'd1;
      end
      if (stall && busy_reg && perf_stall_reg != 16'hFFFF) begin
        perf_stall_reg <= perf_stall_reg + 16'd1;
      end
    end
  end

  assign perf_busy_cyc  = perf_busy_reg;
  assign perf_stall_cyc = perf_stall_reg;
`endif

  assign busy      = busy_reg;
  assign done      = done_reg;
  assign rd_en     = rd_fire;
  assign rd_row    = row_reg;
  assign rd_grp    = grp_reg;
  assign out_valid = out_valid_reg;
  assign out_last  = last_beat;

endmodule
